// File: rtl/ram_scan_reader.sv
// Read-only scan sequencer for a small synchronous RAM: walks addresses, absorbs the
// registered read latency and holds each captured address/data pair for display.
module ram_scan_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1,
    parameter int DWELL  = 50000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              continuous,
    input  logic              step_mode,
    input  logic              step,
    input  logic              pause,
    input  logic              stop,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] disp_address,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);
    localparam int LAT_W   = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam int DWELL_W = (DWELL > 2) ? $clog2(DWELL) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DWELL   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
    logic [ADDR_W-1:0]   disp_address_q, disp_address_d;
    logic [DATA_W-1:0]   disp_data_q, disp_data_d;
    logic                disp_valid_q, disp_valid_d;
    logic                done_q, done_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic                advance;

    always_comb begin
        state_d        = state_q;
        ram_address_d  = ram_address_q;
        disp_address_d = disp_address_q;
        disp_data_d    = disp_data_q;
        disp_valid_d   = disp_valid_q;
        done_d         = 1'b0;
        lat_cnt_d      = lat_cnt_q;
        dwell_cnt_d    = dwell_cnt_q;
        advance        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    ram_address_d = start_addr;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                lat_cnt_d = LAT_W'(RD_LAT - 1);
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt_q == '0) state_d = S_CAPTURE;
                else                 lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end
            S_CAPTURE: begin
                disp_data_d    = ram_q;
                disp_address_d = ram_address_q;
                disp_valid_d   = 1'b1;
                dwell_cnt_d    = DWELL_W'(DWELL - 1);
                state_d        = S_DWELL;
            end
            S_DWELL: begin
                // The CAPTURE cycle is the first held cycle, so the word advances one
                // count early: address period is RD_LAT+DWELL+1 cycles.
                if (step_mode) begin
                    advance = step;
                end else if (!pause) begin
                    if (dwell_cnt_q <= DWELL_W'(1)) advance = 1'b1;
                    else                            dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end
                if (advance) begin
                    if (ram_address_q != {ADDR_W{1'b1}}) begin
                        ram_address_d = ram_address_q + ADDR_W'(1);
                        state_d       = S_ISSUE;
                    end else if (continuous) begin
                        ram_address_d = '0;
                        state_d       = S_ISSUE;
                    end else begin
                        state_d      = S_IDLE;
                        done_d       = 1'b1;
                        disp_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort beats both capture and advance in the same cycle.
        if (stop && state_q != S_IDLE) begin
            state_d        = S_IDLE;
            ram_address_d  = ram_address_q;
            disp_address_d = disp_address_q;
            disp_data_d    = disp_data_q;
            disp_valid_d   = 1'b0;
            done_d         = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            ram_address_q  <= '0;
            disp_address_q <= '0;
            disp_data_q    <= '0;
            disp_valid_q   <= 1'b0;
            done_q         <= 1'b0;
            lat_cnt_q      <= '0;
            dwell_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            ram_address_q  <= ram_address_d;
            disp_address_q <= disp_address_d;
            disp_data_q    <= disp_data_d;
            disp_valid_q   <= disp_valid_d;
            done_q         <= done_d;
            lat_cnt_q      <= lat_cnt_d;
            dwell_cnt_q    <= dwell_cnt_d;
        end
    end

    assign ram_address  = ram_address_q;
    assign ram_wren     = 1'b0;
    assign disp_address = disp_address_q;
    assign disp_data    = disp_data_q;
    assign disp_valid   = disp_valid_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Bench for ram_scan_reader: directed timing checks plus randomized scans compared
// every cycle against a schedule-level model of the scan.
module tb_ram_scan_reader;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int RD_LAT = 1;
  localparam int DWELL  = 4;
  localparam int HOLD_EDGES = (DWELL > 1) ? DWELL - 1 : 1;
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic              start, continuous, step_mode, step, pause, stop;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] ram_address, disp_address;
  logic [DATA_W-1:0] ram_q, disp_data;
  logic              ram_wren, disp_valid, busy, done;
  logic [2:0]        dbg_state;

  ram_scan_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .DWELL(DWELL)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
    .continuous(continuous), .step_mode(step_mode), .step(step), .pause(pause),
    .stop(stop), .ram_address(ram_address), .ram_wren(ram_wren), .ram_q(ram_q),
    .disp_address(disp_address), .disp_data(disp_data), .disp_valid(disp_valid),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // RAM with one-cycle registered read
  logic [DATA_W-1:0] mem [32];
  always @(posedge clock) ram_q <= mem[ram_address];

  // scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: a word is fetched RD_LAT+2 edges after it is requested and held
  // for DWELL-1 unpaused edges (or until a step in step mode)
  logic              m_busy, m_valid, m_done;
  logic [ADDR_W-1:0] m_addr, m_daddr;
  logic [DATA_W-1:0] m_ddata;
  int                m_fetch, m_held;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_valid <= 0; m_done <= 0;
      m_addr <= '0; m_daddr <= '0; m_ddata <= '0;
      m_fetch <= 0; m_held <= 0;
    end else begin
      automatic logic              b = m_busy, v = m_valid, d = 1'b0, adv = 1'b0;
      automatic logic [ADDR_W-1:0] a = m_addr, da = m_daddr;
      automatic logic [DATA_W-1:0] dd = m_ddata;
      automatic int                f = m_fetch, h = m_held;
      if (!b) begin
        if (start && !stop) begin
          b = 1; a = start_addr; f = RD_LAT + 2;
        end
      end else if (stop) begin
        b = 0; v = 0; f = 0;
      end else if (f > 0) begin
        f--;
        if (f == 0) begin
          da = a; dd = mem[a]; v = 1; h = 0;
        end
      end else begin
        if (step_mode) adv = step;
        else if (!pause) begin
          h++;
          adv = (h >= HOLD_EDGES);
        end
        if (adv) begin
          if (a != LAST) begin a = a + 1'b1; f = RD_LAT + 2; end
          else if (continuous) begin a = '0; f = RD_LAT + 2; end
          else begin b = 0; d = 1; v = 0; end
        end
      end
      m_busy <= b; m_valid <= v; m_done <= d; m_addr <= a;
      m_daddr <= da; m_ddata <= dd; m_fetch <= f; m_held <= h;
    end
  end

  // compare process
  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("disp_valid", disp_valid, m_valid);
      chk("disp_address", disp_address, m_daddr);
      chk("disp_data", disp_data, m_ddata);
      chk("ram_address", ram_address, m_addr);
      chk("ram_wren", ram_wren, 0);
    end
  end

  // driver tasks
  task automatic pulse_start(input logic [ADDR_W-1:0] a);
    start_addr = a;
    start = 1;
    @(negedge clock);
    start = 0;
  endtask

  task automatic stop_scan();
    stop = 1;
    @(negedge clock);
    stop = 0;
    @(negedge clock);
  endtask

  initial begin
    reset = 1; start = 0; start_addr = '0; continuous = 0; step_mode = 0;
    step = 0; pause = 0; stop = 0;
    for (int i = 0; i < 32; i++) mem[i] = 4'(i) ^ 4'hA;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 0;
    chk_en = 1;

    // idle after reset
    repeat (20) @(negedge clock);
    chk("idle_busy", busy, 0);
    chk("idle_valid", disp_valid, 0);
    chk("idle_addr", ram_address, 0);

    // single pass from 0
    pulse_start(5'd0);
    repeat (2) @(negedge clock);
    chk("first_pair_early", disp_valid, 0);
    @(negedge clock);
    chk("first_addr", disp_address, 0);
    chk("first_data", disp_data, 4'hA);
    chk("first_valid", disp_valid, 1);
    repeat (5) @(negedge clock);
    chk("hold_addr0", disp_address, 0);
    @(negedge clock);
    chk("second_addr", disp_address, 1);
    chk("second_data", disp_data, 4'hB);
    repeat (180) @(negedge clock);
    chk("last_addr", disp_address, 31);
    chk("last_data", disp_data, 4'h5);
    repeat (2) @(negedge clock);
    chk("pre_done", done, 0);
    chk("pre_done_valid", disp_valid, 1);
    @(negedge clock);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", disp_valid, 0);
    @(negedge clock);
    chk("done_once", done, 0);

    // continuous wrap
    continuous = 1;
    pulse_start(5'd30);
    repeat (3) @(negedge clock);
    chk("wrap_a30", disp_address, 30);
    chk("wrap_d30", disp_data, 4'h4);
    repeat (6) @(negedge clock);
    chk("wrap_a31", disp_address, 31);
    chk("wrap_d31", disp_data, 4'h5);
    repeat (6) @(negedge clock);
    chk("wrap_a0", disp_address, 0);
    chk("wrap_d0", disp_data, 4'hA);
    repeat (6) @(negedge clock);
    chk("wrap_a1", disp_address, 1);
    chk("wrap_d1", disp_data, 4'hB);
    stop_scan();
    chk("wrap_stopped", busy, 0);
    continuous = 0;

    // stop while waiting on the second word: capture of 13 must not happen
    pulse_start(5'd12);
    repeat (7) @(negedge clock);
    stop = 1;
    @(negedge clock);
    stop = 0;
    chk("stop_busy", busy, 0);
    chk("stop_valid", disp_valid, 0);
    chk("stop_done", done, 0);
    chk("stop_addr_held", disp_address, 12);
    @(negedge clock);
    chk("stop_no_done", done, 0);

    // start and stop together in idle
    start_addr = 5'd7; start = 1; stop = 1;
    @(negedge clock);
    start = 0; stop = 0;
    chk("startstop_idle", busy, 0);
    chk("startstop_addr", ram_address, 13);

    // start while busy is ignored
    pulse_start(5'd10);
    repeat (4) @(negedge clock);
    start_addr = 5'd20; start = 1;
    repeat (3) @(negedge clock);
    start = 0;
    repeat (2) @(negedge clock);
    chk("norestart_addr", disp_address, 11);
    chk("norestart_data", disp_data, 4'h1);
    stop_scan();

    // step mode
    step_mode = 1;
    pulse_start(5'd5);
    repeat (100) @(negedge clock);
    chk("step_hold", disp_address, 5);
    step = 1;
    @(negedge clock);
    step = 0;
    repeat (2) @(negedge clock);
    chk("step_early", disp_address, 5);
    @(negedge clock);
    chk("step_addr", disp_address, 6);
    chk("step_data", disp_data, 4'hC);
    stop_scan();
    step_mode = 0;

    // pause extends the hold by exactly its length
    pulse_start(5'd8);
    repeat (3) @(negedge clock);
    pause = 1;
    repeat (10) @(negedge clock);
    pause = 0;
    repeat (5) @(negedge clock);
    chk("pause_hold", disp_address, 8);
    @(negedge clock);
    chk("pause_addr", disp_address, 9);
    chk("pause_data", disp_data, 4'h3);
    stop_scan();

    // async reset between edges while dwelling
    pulse_start(5'd3);
    repeat (4) @(negedge clock);
    chk("pre_rst_busy", busy, 1);
    #2 reset = 1;
    #1;
    chk("arst_ram_addr", ram_address, 0);
    chk("arst_disp_addr", disp_address, 0);
    chk("arst_disp_data", disp_data, 0);
    chk("arst_valid", disp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clock);
    reset = 0;

    // randomized scans with random RAM contents
    for (int i = 0; i < 32; i++) mem[i] = 4'($urandom_range(0, 15));
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      start      = ($urandom_range(0, 19) == 0);
      start_addr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 49) == 0) continuous = ~continuous;
      if ($urandom_range(0, 79) == 0) step_mode = ~step_mode;
      step  = ($urandom_range(0, 5) == 0);
      pause = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 99) == 0);
    end
    start = 0; step = 0; pause = 0; continuous = 0; step_mode = 0;
    stop_scan();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
